// File: rtl/serial_paralelo_sync_if.sv
// Serial-in / word-out bundle for the comma-aligned deserializer.
// The link side (master) drives the bit stream; the deserializer (slave) returns words and status.
interface serial_paralelo_sync_if #(
  parameter int WIDTH = 8
);
  logic             serial_in;
  logic             serial_valid;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             active_out;
  logic             idle_out;
  logic             lock_err;

  modport master (
    output serial_in, serial_valid,
    input  data_out, data_valid, active_out, idle_out, lock_err
  );

  modport slave (
    input  serial_in, serial_valid,
    output data_out, data_valid, active_out, idle_out, lock_err
  );
endinterface

// File: rtl/serial_paralelo_sync.sv
// Comma-aligned serial-to-parallel converter: hunts for COMMA, verifies alignment,
// then emits words on each boundary and drops lock on repeated off-boundary commas.
//
// state  | meaning
// HUNT   | checking every bit position for a COMMA
// VERIFY | counting COMMAs on the candidate word boundary
// LOCKED | aligned; non-COMMA boundary words are delivered
module serial_paralelo_sync #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA      = WIDTH'(8'hBC),
  parameter int               SYNC_COUNT = 4,
  parameter int               LOSS_COUNT = 2
) (
  input  logic                  clk_32f,
  input  logic                  reset,
  serial_paralelo_sync_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam int CC_W  = $clog2(SYNC_COUNT + 1);
  localparam int MC_W  = $clog2(LOSS_COUNT + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CC_W-1:0]  CC_MAX   = CC_W'(SYNC_COUNT);
  localparam logic [MC_W-1:0]  MC_MAX   = MC_W'(LOSS_COUNT);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CC_W-1:0]  comma_cnt_q, comma_cnt_d;
  logic [MC_W-1:0]  miss_cnt_q, miss_cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             dv_q, dv_d;
  logic             active_q, active_d;
  logic             idle_q, idle_d;
  logic             lerr_q, lerr_d;

  logic [WIDTH-1:0] window;
  logic             is_comma;
  logic             at_boundary;
  logic             realign;
  logic [CC_W-1:0]  comma_next;
  logic [MC_W-1:0]  miss_next;

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q     <= HUNT;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
      miss_cnt_q  <= '0;
      data_q      <= '0;
      dv_q        <= 1'b0;
      active_q    <= 1'b0;
      idle_q      <= 1'b0;
      lerr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      data_q      <= data_d;
      dv_q        <= dv_d;
      active_q    <= active_d;
      idle_q      <= idle_d;
      lerr_q      <= lerr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    bit_cnt_d   = bit_cnt_q;
    comma_cnt_d = comma_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    data_d      = data_q;
    dv_d        = 1'b0;
    active_d    = active_q;
    idle_d      = idle_q;
    lerr_d      = 1'b0;
    realign     = 1'b0;

    window      = {sr_q[WIDTH-2:0], bus.serial_in};
    is_comma    = (window == COMMA);
    at_boundary = (bit_cnt_q == LAST_BIT);
    comma_next  = (comma_cnt_q < CC_MAX) ? comma_cnt_q + CC_W'(1) : comma_cnt_q;
    miss_next   = (miss_cnt_q < MC_MAX) ? miss_cnt_q + MC_W'(1) : miss_cnt_q;

    if (bus.serial_valid) begin
      sr_d = window;
      if (state_q != HUNT)
        bit_cnt_d = at_boundary ? '0 : bit_cnt_q + CNT_W'(1);

      unique case (state_q)
        HUNT: begin
          if (is_comma) realign = 1'b1;
        end
        VERIFY: begin
          if (at_boundary) begin
            if (is_comma) begin
              comma_cnt_d = comma_next;
              if (comma_next == CC_MAX) begin
                state_d  = LOCKED;
                active_d = 1'b1;
                idle_d   = 1'b1;
              end
            end else begin
              state_d     = HUNT;
              comma_cnt_d = '0;
            end
          end
        end
        LOCKED: begin
          if (at_boundary) begin
            if (is_comma) begin
              idle_d     = 1'b1;
              miss_cnt_d = '0;
            end else begin
              data_d = window;
              dv_d   = 1'b1;
              idle_d = 1'b0;
            end
          end else if (is_comma) begin
            miss_cnt_d = miss_next;
            if (miss_next == MC_MAX) begin
              lerr_d  = 1'b1;
              realign = 1'b1;
            end
          end
        end
        default: state_d = HUNT;
      endcase

      // Realignment treats the current comma as the first of a fresh verify run.
      if (realign) begin
        bit_cnt_d   = '0;
        comma_cnt_d = CC_W'(1);
        miss_cnt_d  = '0;
        if (SYNC_COUNT == 1) begin
          state_d  = LOCKED;
          active_d = 1'b1;
          idle_d   = 1'b1;
        end else begin
          state_d  = VERIFY;
          active_d = 1'b0;
          idle_d   = 1'b0;
        end
      end
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = dv_q;
  assign bus.active_out = active_q;
  assign bus.idle_out   = idle_q;
  assign bus.lock_err   = lerr_q;
endmodule

// File: tb/tb_serial_paralelo_sync.sv
// Directed bench for serial_paralelo_sync: reset, lock, data, stall, loss of lock, broken verify.
module tb_serial_paralelo_sync;
  logic clk_32f = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   dv_cnt   = 0;
  int   le_cnt   = 0;

  always #5 clk_32f = ~clk_32f;

  serial_paralelo_sync_if #(.WIDTH(8)) bus ();

  serial_paralelo_sync #(
    .WIDTH(8), .COMMA(8'hBC), .SYNC_COUNT(4), .LOSS_COUNT(2)
  ) dut (
    .clk_32f (clk_32f),
    .reset   (reset),
    .bus     (bus)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one bit slot at the falling edge, sample outputs just after the rising edge.
  task automatic step(input logic v, input logic b);
    @(negedge clk_32f);
    bus.serial_valid = v;
    bus.serial_in    = b;
    @(posedge clk_32f);
    #1;
    if (bus.data_valid === 1'b1) dv_cnt++;
    if (bus.lock_err === 1'b1) le_cnt++;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) step(1'b1, w[i]);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    repeat (3) step(1'b1, 1'($urandom_range(0, 1)));
    check_val({tag, "_data_out"},   32'(bus.data_out), 32'h0);
    check_val({tag, "_data_valid"}, 32'(bus.data_valid), 32'h0);
    check_val({tag, "_active"},     32'(bus.active_out), 32'h0);
    check_val({tag, "_idle"},       32'(bus.idle_out), 32'h0);
    check_val({tag, "_lock_err"},   32'(bus.lock_err), 32'h0);
    @(negedge clk_32f);
    reset            = 1'b0;
    bus.serial_valid = 1'b0;
  endtask

  initial begin
    reset            = 1'b1;
    bus.serial_in    = 1'b0;
    bus.serial_valid = 1'b0;

    do_reset("rst");

    // lock after four aligned commas preceded by random bits
    dv_cnt = 0;
    repeat (3) step(1'b1, 1'($urandom_range(0, 1)));
    repeat (3) send_word(8'hBC);
    check_val("lock_early_active", 32'(bus.active_out), 32'h0);
    send_word(8'hBC);
    check_val("lock_active", 32'(bus.active_out), 32'h1);
    check_val("lock_idle",   32'(bus.idle_out), 32'h1);
    check_val("lock_no_dv",  32'(dv_cnt), 32'h0);

    // data words
    dv_cnt = 0;
    send_word(8'h5A);
    check_val("d1_pulse",    32'(bus.data_valid), 32'h1);
    check_val("d1_data",     32'(bus.data_out), 32'h5A);
    check_val("d1_idle",     32'(bus.idle_out), 32'h0);
    check_val("d1_dv_count", 32'(dv_cnt), 32'h1);
    send_word(8'h3C);
    check_val("d2_data",     32'(bus.data_out), 32'h3C);
    check_val("d2_dv_count", 32'(dv_cnt), 32'h2);
    send_word(8'hBC);
    check_val("d3_idle",     32'(bus.idle_out), 32'h1);
    check_val("d3_data_hold", 32'(bus.data_out), 32'h3C);
    check_val("d3_dv_count", 32'(dv_cnt), 32'h2);
    check_val("d3_active",   32'(bus.active_out), 32'h1);

    // stall in the middle of 0xA5
    dv_cnt = 0;
    step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
    repeat (5) step(1'b0, 1'($urandom_range(0, 1)));
    check_val("stall_no_dv", 32'(dv_cnt), 32'h0);
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b1); step(1'b1, 1'b0);
    check_val("stall_pre_last_dv", 32'(bus.data_valid), 32'h0);
    step(1'b1, 1'b1);
    check_val("stall_pulse",    32'(bus.data_valid), 32'h1);
    check_val("stall_data",     32'(bus.data_out), 32'hA5);
    step(1'b0, 1'b0);
    check_val("stall_pulse_end", 32'(bus.data_valid), 32'h0);
    check_val("stall_hold",     32'(bus.data_out), 32'hA5);
    check_val("stall_dv_count", 32'(dv_cnt), 32'h1);
    send_word(8'hBC);

    // loss of lock: one extra bit shifts every following comma off the boundary
    le_cnt = 0;
    step(1'b1, 1'b0);
    send_word(8'hBC);
    check_val("loss1_no_err", 32'(le_cnt), 32'h0);
    check_val("loss1_active", 32'(bus.active_out), 32'h1);
    send_word(8'hBC);
    check_val("loss2_err_pulse", 32'(bus.lock_err), 32'h1);
    check_val("loss2_active",    32'(bus.active_out), 32'h0);
    check_val("loss2_idle",      32'(bus.idle_out), 32'h0);
    check_val("loss2_data_hold", 32'(bus.data_out), 32'h5E);
    send_word(8'hBC);
    send_word(8'hBC);
    check_val("relock_early_active", 32'(bus.active_out), 32'h0);
    send_word(8'hBC);
    check_val("relock_active", 32'(bus.active_out), 32'h1);
    check_val("relock_idle",   32'(bus.idle_out), 32'h1);
    check_val("relock_err_count", 32'(le_cnt), 32'h1);

    // reset while locked, then a broken verify run
    do_reset("rst2");
    send_word(8'hBC);
    send_word(8'hBC);
    send_word(8'h00);
    check_val("brk_active_00", 32'(bus.active_out), 32'h0);
    repeat (3) send_word(8'hBC);
    check_val("brk_active_3", 32'(bus.active_out), 32'h0);
    send_word(8'hBC);
    check_val("brk_active_4", 32'(bus.active_out), 32'h1);
    check_val("brk_idle_4",   32'(bus.idle_out), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_paralelo_sync.md
SERIAL_PARALELO_SYNC -- requirements
Module: serial_paralelo_sync

Interface
REQ-001 Parameter WIDTH, default 8: deserialized word width, legal range 4..32.
REQ-002 Parameter COMMA, default 8'hBC (WIDTH bits): alignment/idle character.
REQ-003 Parameter SYNC_COUNT, default 4: consecutive aligned COMMAs required to lock, legal range >=1.
REQ-004 Parameter LOSS_COUNT, default 2: consecutive off-boundary COMMAs that drop lock, legal range >=1.
REQ-005 clk_32f  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 serial_in  input  1  serial bit, MSB of each word first.
REQ-008 serial_valid  input  1  serial_in is sampled only when high (bit enable/stall).
REQ-009 data_out  output  WIDTH  last non-COMMA word received while locked.
REQ-010 data_valid  output  1  one-cycle pulse, data_out updated this cycle.
REQ-011 active_out  output  1  high while in LOCKED.
REQ-012 idle_out  output  1  high while locked and last aligned word was COMMA.
REQ-013 lock_err  output  1  one-cycle pulse on loss of lock.

Function
REQ-014 When serial_valid=1, the shift register SHALL update to {sr[WIDTH-2:0], serial_in}; "window" means the updated value; when serial_valid=0, sr, counters, state and level outputs hold and the pulses data_valid and lock_err SHALL be 0.
REQ-015 The FSM SHALL have states HUNT, VERIFY and LOCKED, plus bit_cnt (0..WIDTH-1), comma_cnt and miss_cnt.
REQ-016 HUNT: every sampled bit, window==COMMA -> bit_cnt=0, comma_cnt=1, go VERIFY; if SYNC_COUNT==1, go LOCKED directly.
REQ-017 Word boundary = the sampled bit that brings bit_cnt from WIDTH-1 back to 0; bit_cnt increments per sampled bit in VERIFY/LOCKED only.
REQ-018 VERIFY at boundary: window==COMMA -> comma_cnt+1; reaching SYNC_COUNT -> LOCKED; window!=COMMA -> HUNT, comma_cnt=0; off-boundary windows are ignored.
REQ-019 LOCKED at boundary: window==COMMA -> idle_out=1, miss_cnt=0, no data_valid; otherwise data_out=window, data_valid=1, idle_out=0.
REQ-020 LOCKED off-boundary window==COMMA -> miss_cnt+1; on reaching LOSS_COUNT: lock_err=1, active_out=0, idle_out=0, miss_cnt=0, and realign on that comma (bit_cnt=0, comma_cnt=1, VERIFY; LOCKED directly if SYNC_COUNT==1).
REQ-021 All outputs SHALL be registered: a response appears in the cycle after the clock edge that sampled the deciding bit, giving a latency of 1 cycle from the last bit of a word.
REQ-022 active_out SHALL rise in the same cycle as the transition into LOCKED, and SHALL set idle_out=1 (the locking word is a COMMA).
REQ-023 data_out SHALL hold its value between data_valid pulses and SHALL keep its value on loss of lock.
REQ-024 Counters SHALL saturate and never wrap: comma_cnt <= SYNC_COUNT, miss_cnt <= LOSS_COUNT.

Reset
REQ-025 While reset=1 at a clock edge, the block SHALL enter HUNT, clear sr, bit_cnt, comma_cnt and miss_cnt, and drive data_out=0, data_valid=0, active_out=0, idle_out=0, lock_err=0; reset SHALL take priority over serial_valid.
REQ-026 Reset asserted mid-word or while locked SHALL discard all partial state; relock SHALL require a full SYNC_COUNT sequence after reset is released.

Verification
REQ-027 Reset: hold reset for 3 cycles with random serial_in -> all outputs 0, active_out 0.
REQ-028 Lock: send 3 random bits, then 4x 0xBC (WIDTH=8, SYNC_COUNT=4, serial_valid=1) -> active_out=1 and idle_out=1 one cycle after the 32nd comma bit, data_valid never pulses.
REQ-029 Data: locked, send 0x5A then 0x3C -> data_valid pulses once per word, data_out=0x5A then 0x3C, idle_out 0; then send 0xBC -> idle_out=1, data_out stays 0x3C.
REQ-030 Broken verify: send 2x 0xBC, then 0x00, then 4x 0xBC -> active_out stays 0 through the 0x00, then rises after the 4th subsequent comma.
REQ-031 Stall: locked, drop serial_valid for 5 cycles after bit 3 of 0xA5 -> exactly one data_valid pulse, data_out=0xA5, latency measured from the final sampled bit.
REQ-032 Loss: locked, insert one extra bit, then send 0xBC repeatedly -> lock_err pulses on the 2nd off-boundary comma, active_out falls, active_out returns to 1 after 3 more aligned commas.
